// File: rtl/game_ctrl_if.sv
// Signal bundle between game_ctrl and the FlappyBird pixel/address datapath.
// The hiscore signal exists only when GAME_CTRL_HISCORE_EN is defined.
interface game_ctrl_if;
  logic [9:0]  keydata;
  logic        hit;
  logic        pass;
  logic        frame_tick;
  logic [1:0]  mode;
  logic        death;
  logic [8:0]  birdy;
  logic [10:0] scroll;
  logic [11:0] score;
`ifdef GAME_CTRL_HISCORE_EN
  logic [11:0] hiscore;

  modport master (
    input  keydata, hit, pass,
    output frame_tick, mode, death, birdy, scroll, score, hiscore
  );
  modport slave (
    output keydata, hit, pass,
    input  frame_tick, mode, death, birdy, scroll, score, hiscore
  );
`else
  modport master (
    input  keydata, hit, pass,
    output frame_tick, mode, death, birdy, scroll, score
  );
  modport slave (
    output keydata, hit, pass,
    input  frame_tick, mode, death, birdy, scroll, score
  );
`endif
endinterface

// File: rtl/game_ctrl.sv
// FlappyBird game sequencer: PS/2 key events, TITLE/RUN/PAUSE/DEAD FSM, physics tick, bird/scroll/score.
// Define GAME_CTRL_HISCORE_EN to add the hiscore register and output.
module game_ctrl #(
  parameter int unsigned TICK_DIV    = 524288,
  parameter int unsigned BIRD_Y_INIT = 200,
  parameter int unsigned BIRD_Y_MAX  = 450,
  parameter int unsigned FLAP_STEP   = 3,
  parameter int unsigned FLAP_MIN    = 10,
  parameter int unsigned SCROLL_WRAP = 1920
) (
  input logic         clk,
  input logic         rst,
  game_ctrl_if.master bus
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [9:0] KEY_W = 10'h01D;
  localparam logic [9:0] KEY_S = 10'h01B;
  localparam logic [9:0] KEY_A = 10'h01C;
  localparam logic [9:0] KEY_P = 10'h04D;

  typedef enum logic [1:0] {
    TITLE = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DEAD  = 2'b11
  } mode_t;

  mode_t       mode, mode_nx;
  logic        death;
  logic [TW-1:0] tick_cnt;
  logic        frame_tick;
  logic [9:0]  kd_q;
  logic [8:0]  birdy, birdy_nx;
  logic [10:0] scroll, scroll_nx;
  logic [11:0] score, score_nx;
  logic        init_game;
  logic        ev_a, ev_s, ev_p;
  logic        flap;
  logic [9:0]  fall;
  logic [11:0] score_inc;

  // Edge-detected key events; a held key produces a single event
  assign ev_a = (bus.keydata == KEY_A) && (kd_q != KEY_A);
  assign ev_s = (bus.keydata == KEY_S) && (kd_q != KEY_S);
  assign ev_p = (bus.keydata == KEY_P) && (kd_q != KEY_P);

  // Flap is level-sensitive and suppressed near the ceiling
  assign flap      = (bus.keydata == KEY_W) && (birdy >= 9'(FLAP_MIN));
  assign fall      = 10'(birdy) + 10'd1 - (flap ? 10'(FLAP_STEP) : 10'd0);
  assign score_inc = (score == 12'hFFF) ? score : score + 12'd1;

  // Free-running physics tick and key history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      frame_tick <= 1'b0;
      kd_q       <= '0;
    end else begin
      frame_tick <= (tick_cnt == TW'(TICK_DIV - 1));
      tick_cnt   <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + TW'(1);
      kd_q       <= bus.keydata;
    end
  end

  // Next-state and next-datapath-value decision
  always_comb begin
    mode_nx   = mode;
    birdy_nx  = birdy;
    scroll_nx = scroll;
    score_nx  = score;
    init_game = 1'b0;
    unique case (mode)
      TITLE: begin
        if (ev_a) init_game = 1'b1;
      end
      RUN: begin
        if (bus.hit) begin
          mode_nx = DEAD;
        end else if (ev_s) begin
          init_game = 1'b1;
        end else begin
          if (ev_p) begin
            mode_nx = PAUSE;
          end else if (frame_tick) begin
            if (fall >= 10'(BIRD_Y_MAX)) begin
              birdy_nx = 9'(BIRD_Y_MAX);
              mode_nx  = DEAD;
            end else begin
              birdy_nx = fall[8:0];
            end
            scroll_nx = (scroll == 11'(SCROLL_WRAP - 1)) ? 11'd0 : scroll + 11'd1;
          end
          if (bus.pass) score_nx = score_inc;
        end
      end
      PAUSE: begin
        if (ev_s)      init_game = 1'b1;
        else if (ev_p) mode_nx   = RUN;
      end
      DEAD: begin
        if (ev_s)      init_game = 1'b1;
        else if (ev_a) mode_nx   = TITLE;
      end
    endcase
    if (init_game) begin
      mode_nx   = RUN;
      birdy_nx  = 9'(BIRD_Y_INIT);
      scroll_nx = '0;
      score_nx  = '0;
    end
  end

  // Game state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode   <= TITLE;
      death  <= 1'b0;
      birdy  <= 9'(BIRD_Y_INIT);
      scroll <= '0;
      score  <= '0;
    end else begin
      mode   <= mode_nx;
      death  <= (mode_nx == DEAD);
      birdy  <= birdy_nx;
      scroll <= scroll_nx;
      score  <= score_nx;
    end
  end

  assign bus.frame_tick = frame_tick;
  assign bus.mode       = mode;
  assign bus.death      = death;
  assign bus.birdy      = birdy;
  assign bus.scroll     = scroll;
  assign bus.score      = score;

`ifdef GAME_CTRL_HISCORE_EN
  logic [11:0] hiscore;

  // Captured on the cycle the game ends, using the final score of that game
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hiscore <= '0;
    end else if ((mode != DEAD) && (mode_nx == DEAD) && (score_nx > hiscore)) begin
      hiscore <= score_nx;
    end
  end

  assign bus.hiscore = hiscore;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus randomized keys/hit/pass/rst
// checked every cycle against a behavioural game model.
`timescale 1ns/1ps
module tb_game_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam logic [9:0] K_W = 10'h01D;
  localparam logic [9:0] K_S = 10'h01B;
  localparam logic [9:0] K_A = 10'h01C;
  localparam logic [9:0] K_P = 10'h04D;

  logic clk = 1'b0;
  logic rst = 1'b1;

  game_ctrl_if bus();

  game_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state (mode encoded 0 TITLE, 1 RUN, 2 PAUSE, 3 DEAD)
  int m_mode, m_by, m_sc, m_score, m_hi, m_n, m_prev;
  bit m_ft;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_by = 200; m_sc = 0; m_score = 0;
    m_n = 0; m_ft = 0; m_prev = 0; m_hi = 0;
  endtask

  task automatic model_step();
    int key, nb;
    bit ea, es, ep, tick, init, died;
    if (rst) begin
      model_reset();
      return;
    end
    key  = int'(bus.keydata);
    ea   = (key == K_A) && (m_prev != K_A);
    es   = (key == K_S) && (m_prev != K_S);
    ep   = (key == K_P) && (m_prev != K_P);
    tick = m_ft;
    init = 0;
    died = 0;
    case (m_mode)
      0: if (ea) init = 1;
      1: begin
        if (bus.hit) begin
          m_mode = 3;
          died = 1;
        end else if (es) begin
          init = 1;
        end else begin
          if (ep) begin
            m_mode = 2;
          end else if (tick) begin
            nb = m_by + 1 - (((key == K_W) && (m_by >= 10)) ? 3 : 0);
            if (nb >= 450) begin
              m_by = 450;
              m_mode = 3;
              died = 1;
            end else begin
              m_by = nb;
            end
            m_sc = (m_sc + 1) % 1920;
          end
          if (bus.pass && m_score < 4095) m_score++;
        end
      end
      2: if (es) init = 1; else if (ep) m_mode = 1;
      default: if (es) init = 1; else if (ea) m_mode = 0;
    endcase
    if (died && m_score > m_hi) m_hi = m_score;
    if (init) begin
      m_mode = 1; m_by = 200; m_sc = 0; m_score = 0;
    end
    m_prev = key;
    m_n++;
    m_ft = (m_n % TICK_DIV) == 0;
  endtask

  // Model advance and full output comparison every cycle
  always @(posedge clk) begin
    model_step();
    #1;
    check("frame_tick", int'(bus.frame_tick), int'(m_ft));
    check("mode",       int'(bus.mode),       m_mode);
    check("death",      int'(bus.death),      (m_mode == 3) ? 1 : 0);
    check("birdy",      int'(bus.birdy),      m_by);
    check("scroll",     int'(bus.scroll),     m_sc);
    check("score",      int'(bus.score),      m_score);
`ifdef GAME_CTRL_HISCORE_EN
    check("hiscore",    int'(bus.hiscore),    m_hi);
`endif
  end

  task automatic key_event(input logic [9:0] k);
    @(negedge clk) bus.keydata = k;
    @(negedge clk) bus.keydata = '0;
  endtask

  // Returns just after the posedge at which the next physics tick is applied
  task automatic wait_tick(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.frame_tick) ok = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int t, i, cnt, np, hold;
    bus.keydata = '0;
    bus.hit     = 1'b0;
    bus.pass    = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mode",   int'(bus.mode),   0);
    check("rst_birdy",  int'(bus.birdy),  200);
    check("rst_scroll", int'(bus.scroll), 0);
    check("rst_score",  int'(bus.score),  0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.frame_tick) cnt++;
    end
    check("tick_count_12clk", cnt, 3);

    // A held 20 clocks: one RUN entry, then 5 falling ticks
    bus.keydata = K_A;
    t = 0; i = 0;
    while (t < 5 && i < 200) begin
      @(negedge clk);
      i++;
      if (i == 20) bus.keydata = '0;
      if (bus.frame_tick && bus.mode == 2'b01) t++;
    end
    if (t < 5) timeout("a_start_ticks");
    @(posedge clk); #1;
    bus.keydata = '0;
    check("a_start_mode",   int'(bus.mode),   1);
    check("a_start_birdy",  int'(bus.birdy),  205);
    check("a_start_scroll", int'(bus.scroll), 5);

    // Restart then flap for three ticks
    key_event(K_S);
    bus.keydata = K_W;
    wait_tick(ok); check("flap1", int'(bus.birdy), 198);
    wait_tick(ok); check("flap2", int'(bus.birdy), 196);
    wait_tick(ok); check("flap3", int'(bus.birdy), 194);

    // Ceiling: at 9 the bird only falls
    t = 0;
    while (bus.birdy != 9'd9 && t < 200) begin wait_tick(ok); t++; end
    if (t >= 200) timeout("reach_birdy9");
    wait_tick(ok);
    check("ceiling_fall", int'(bus.birdy), 10);

    // Scroll wrap while hovering at the ceiling
    t = 0;
    while (bus.scroll != 11'd1919 && t < 2000) begin wait_tick(ok); t++; end
    if (t >= 2000) timeout("reach_scroll1919");
    wait_tick(ok);
    check("scroll_wrap", int'(bus.scroll), 0);
    check("scroll_wrap_mode", int'(bus.mode), 1);

    // Fall to the floor collecting 7 pipes on the way
    bus.keydata = '0;
    t = 0; np = 0;
    while (bus.birdy != 9'd449 && t < 600) begin
      if (np < 7) begin
        @(negedge clk) bus.pass = 1'b1;
        @(negedge clk) bus.pass = 1'b0;
        np++;
      end
      wait_tick(ok);
      t++;
    end
    if (t >= 600) timeout("reach_birdy449");
    wait_tick(ok);
    check("floor_birdy", int'(bus.birdy), 450);
    check("floor_mode",  int'(bus.mode),  3);
    check("floor_death", int'(bus.death), 1);
    check("dead_score",  int'(bus.score), 7);

    key_event(K_S);
    check("restart_mode",  int'(bus.mode),  1);
    check("restart_score", int'(bus.score), 0);
    check("restart_birdy", int'(bus.birdy), 200);
`ifdef GAME_CTRL_HISCORE_EN
    check("hiscore_kept", int'(bus.hiscore), 7);
`endif

    // Pause: restart on a tick cycle, pause next cycle, hit/pass ignored
    i = 0;
    do begin @(negedge clk); i++; end while (!bus.frame_tick && i < 20);
    bus.keydata = K_S;
    @(negedge clk) bus.keydata = K_P;
    @(negedge clk) bus.keydata = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.hit  = (k % 7 == 3);
      bus.pass = (k % 5 == 1);
    end
    @(negedge clk) begin bus.hit = 1'b0; bus.pass = 1'b0; end
    check("pause_mode",   int'(bus.mode),   2);
    check("pause_birdy",  int'(bus.birdy),  200);
    check("pause_scroll", int'(bus.scroll), 0);
    check("pause_score",  int'(bus.score),  0);
    key_event(K_P);
    check("unpause_mode", int'(bus.mode), 1);

    // hit wins over P
    bus.keydata = K_P;
    bus.hit     = 1'b1;
    @(negedge clk) begin bus.keydata = '0; bus.hit = 1'b0; end
    check("hit_over_p_mode",  int'(bus.mode),  3);
    check("hit_over_p_death", int'(bus.death), 1);

    // Asynchronous reset in the middle of a game
    key_event(K_S);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_mode",   int'(bus.mode),       0);
    check("midrst_birdy",  int'(bus.birdy),      200);
    check("midrst_scroll", int'(bus.scroll),     0);
    check("midrst_score",  int'(bus.score),      0);
    check("midrst_tick",   int'(bus.frame_tick), 0);
    @(negedge clk) rst = 1'b0;

    // Randomized play
    hold = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: bus.keydata = K_W;
          3:       bus.keydata = K_S;
          4:       bus.keydata = K_A;
          5:       bus.keydata = K_P;
          6:       bus.keydata = 10'h123;
          default: bus.keydata = '0;
        endcase
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      bus.hit  = ($urandom_range(0, 199) == 0);
      bus.pass = ($urandom_range(0, 19) == 0);
      rst      = ($urandom_range(0, 1999) == 0);
    end
    @(negedge clk) begin
      bus.keydata = '0; bus.hit = 1'b0; bus.pass = 1'b0; rst = 1'b0;
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
